// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
//   arb_state_t : arbiter FSM states
//   rr_next     : round-robin winner search starting after the last grant
//   *_W         : Wishbone field widths used by the wishboneSlave interface
package wb_arb_pkg;

    localparam int unsigned ADR_W          = 32;
    localparam int unsigned DAT_W          = 32;
    localparam int unsigned SEL_W          = 4;
    localparam int unsigned TGD_W          = 4;
    localparam int unsigned MAX_MASTERS    = 8;
    localparam int unsigned MAX_GRANT_BITS = 3;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    // Scan last+1, last+2, ... modulo n and return the first requester.
    // Returns last when nobody requests (callers qualify with any_req).
    function automatic logic [MAX_GRANT_BITS-1:0] rr_next(
        input logic [MAX_MASTERS-1:0]    req,
        input logic [MAX_GRANT_BITS-1:0] last,
        input int unsigned               n
    );
        logic [MAX_GRANT_BITS-1:0] pick;
        logic                      found;
        int unsigned               idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_MASTERS; k++) begin
            if (k <= n) begin
                idx = (32'(last) + k) % n;
                if (!found && req[idx[MAX_GRANT_BITS-1:0]]) begin
                    pick  = idx[MAX_GRANT_BITS-1:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wishboneSlave.sv
// Wishbone slave-side bundle. Signal names are from the slave's view.
//   slave  modport : used by a slave (receives cyc/stb/..., drives ack/err/...)
//   master modport : used by a master driving this slave
interface wishboneSlave;
    import wb_arb_pkg::*;

    logic             cyc_i;
    logic             stb_i;
    logic             we_i;
    logic [ADR_W-1:0] adr_i;
    logic [DAT_W-1:0] dat_i;
    logic [SEL_W-1:0] sel_i;
    logic [TGD_W-1:0] tgd_i;
    logic             ack_o;
    logic             err_o;
    logic             rty_o;
    logic [DAT_W-1:0] dat_o;
    logic [TGD_W-1:0] tgd_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, tgd_i,
        output ack_o, err_o, rty_o, dat_o, tgd_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, tgd_i,
        input  ack_o, err_o, rty_o, dat_o, tgd_o
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per master
//   last_grant : index of the most recent owner (lowest priority)
//   winner     : first requester after last_grant (valid when any_req)
//   any_req    : at least one request present
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned GRANT_BITS  = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [GRANT_BITS-1:0]  last_grant,
    output logic [GRANT_BITS-1:0]  winner,
    output logic                   any_req
);

    always_comb begin
        winner  = GRANT_BITS'(rr_next(MAX_MASTERS'(req),
                                      MAX_GRANT_BITS'(last_grant),
                                      NUM_MASTERS));
        any_req = |req;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between NUM_MASTERS masters.
//   clk_i   : bus clock
//   reset   : asynchronous active-high reset
//   masters : requesting masters (arbiter is their slave)
//   target  : shared slave (arbiter is its master)
//   grant_o : current owner index, valid while busy_o
//   busy_o  : a master holds the bus
// A grant lasts for the owner's whole cyc; a watchdog forces err when the
// target leaves a strobe unanswered for TIMEOUT cycles (0 disables it).
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned GRANT_BITS  = $clog2(NUM_MASTERS)
) (
    input  logic                  clk_i,
    input  logic                  reset,
    wishboneSlave.slave           masters [NUM_MASTERS],
    wishboneSlave.master          target,
    output logic [GRANT_BITS-1:0] grant_o,
    output logic                  busy_o
);

    localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t            state_q, state_d;
    logic [GRANT_BITS-1:0] grant_d, last_grant, last_d, winner;
    logic [WD_W-1:0]       wd_count, wd_d;
    logic                  any_req;

    logic [NUM_MASTERS-1:0] req, m_stb, m_we, own;
    logic [ADR_W-1:0]       m_adr [NUM_MASTERS];
    logic [DAT_W-1:0]       m_dat [NUM_MASTERS];
    logic [SEL_W-1:0]       m_sel [NUM_MASTERS];
    logic [TGD_W-1:0]       m_tgd [NUM_MASTERS];

    logic             g_cyc, g_stb, g_we;
    logic [ADR_W-1:0] g_adr;
    logic [DAT_W-1:0] g_dat;
    logic [SEL_W-1:0] g_sel;
    logic [TGD_W-1:0] g_tgd;
    logic             t_resp, wd_limit, wd_fire;

    assign busy_o = (state_q == ARB_GRANT);

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
        assign req[i]   = masters[i].cyc_i;
        assign m_stb[i] = masters[i].stb_i;
        assign m_we[i]  = masters[i].we_i;
        assign m_adr[i] = masters[i].adr_i;
        assign m_dat[i] = masters[i].dat_i;
        assign m_sel[i] = masters[i].sel_i;
        assign m_tgd[i] = masters[i].tgd_i;

        assign own[i] = busy_o && (grant_o == GRANT_BITS'(i));

        assign masters[i].ack_o = own[i] & target.ack_o;
        assign masters[i].err_o = own[i] & (target.err_o | wd_fire);
        assign masters[i].rty_o = own[i] & target.rty_o;
        assign masters[i].dat_o = own[i] ? target.dat_o : '0;
        assign masters[i].tgd_o = own[i] ? target.tgd_o : '0;
    end

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .GRANT_BITS  (GRANT_BITS)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Granted master's request; all zero while idle.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_tgd = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (own[i]) begin
                g_cyc = req[i];
                g_stb = m_stb[i];
                g_we  = m_we[i];
                g_adr = m_adr[i];
                g_dat = m_dat[i];
                g_sel = m_sel[i];
                g_tgd = m_tgd[i];
            end
        end
    end

    // The limit cycle withdraws stb from the target; a response that still
    // arrives in that cycle beats the forced err.
    assign t_resp   = target.ack_o | target.err_o | target.rty_o;
    assign wd_limit = (TIMEOUT > 0) && g_stb && (wd_count == WD_W'(TIMEOUT));
    assign wd_fire  = wd_limit && !t_resp;

    assign target.cyc_i = g_cyc;
    assign target.stb_i = g_stb & ~wd_limit;
    assign target.we_i  = g_we;
    assign target.adr_i = g_adr;
    assign target.dat_i = g_dat;
    assign target.sel_i = g_sel;
    assign target.tgd_i = g_tgd;

    always_comb begin
        state_d = state_q;
        grant_d = grant_o;
        last_d  = last_grant;
        wd_d    = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d = ARB_GRANT;
                    grant_d = winner;
                end
            end
            ARB_GRANT: begin
                if (!g_cyc) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_o;
                end else if ((TIMEOUT > 0) && g_stb && !t_resp && !wd_limit) begin
                    wd_d = wd_count + WD_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_o    <= '0;
            last_grant <= GRANT_BITS'(NUM_MASTERS - 1);
            wd_count   <= '0;
        end else begin
            state_q    <= state_d;
            grant_o    <= grant_d;
            last_grant <= last_d;
            wd_count   <= wd_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter with three masters and TIMEOUT=4.
module tb_wb_rr_arbiter;
    import wb_arb_pkg::*;

    localparam int N  = 3;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]     m_cyc, m_stb, m_we;
    logic [ADR_W-1:0] m_adr [N];
    logic [DAT_W-1:0] m_dat [N];
    logic [SEL_W-1:0] m_sel [N];
    logic [TGD_W-1:0] m_tgd [N];
    logic [N-1:0]     m_ack, m_err, m_rty;
    logic [DAT_W-1:0] m_rdat [N];
    logic [TGD_W-1:0] m_rtgd [N];

    logic             t_ack, t_err, t_rty;
    logic [DAT_W-1:0] t_rdat;
    logic [TGD_W-1:0] t_rtgd;

    logic [1:0] grant;
    logic       busy;

    wishboneSlave m_if [N] ();
    wishboneSlave t_if ();

    for (genvar g = 0; g < N; g++) begin : g_m
        assign m_if[g].cyc_i = m_cyc[g];
        assign m_if[g].stb_i = m_stb[g];
        assign m_if[g].we_i  = m_we[g];
        assign m_if[g].adr_i = m_adr[g];
        assign m_if[g].dat_i = m_dat[g];
        assign m_if[g].sel_i = m_sel[g];
        assign m_if[g].tgd_i = m_tgd[g];
        assign m_ack[g]  = m_if[g].ack_o;
        assign m_err[g]  = m_if[g].err_o;
        assign m_rty[g]  = m_if[g].rty_o;
        assign m_rdat[g] = m_if[g].dat_o;
        assign m_rtgd[g] = m_if[g].tgd_o;
    end

    assign t_if.ack_o = t_ack;
    assign t_if.err_o = t_err;
    assign t_if.rty_o = t_rty;
    assign t_if.dat_o = t_rdat;
    assign t_if.tgd_o = t_rtgd;

    wb_rr_arbiter #(
        .NUM_MASTERS (N),
        .TIMEOUT     (TO)
    ) dut (
        .clk_i   (clk),
        .reset   (reset),
        .masters (m_if),
        .target  (t_if),
        .grant_o (grant),
        .busy_o  (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] req_of(input int g);
        if (g < 0) return '0;
        return 128'({m_we[g], m_adr[g], m_dat[g], m_sel[g], m_tgd[g]});
    endfunction

    // owner = -1 means nobody holds the bus.
    task automatic check_outputs(input string tag, input int owner, input logic e_tcyc,
                                 input logic e_tstb, input logic [N-1:0] e_ack,
                                 input logic [N-1:0] e_err, input logic [N-1:0] e_rty);
        check($sformatf("%s busy", tag), 128'(busy), 128'(owner >= 0));
        if (owner >= 0) check($sformatf("%s grant", tag), 128'(grant), 128'(owner));
        check($sformatf("%s tcyc", tag), 128'(t_if.cyc_i), 128'(e_tcyc));
        check($sformatf("%s tstb", tag), 128'(t_if.stb_i), 128'(e_tstb));
        check($sformatf("%s treq", tag),
              128'({t_if.we_i, t_if.adr_i, t_if.dat_i, t_if.sel_i, t_if.tgd_i}), req_of(owner));
        for (int i = 0; i < N; i++)
            check($sformatf("%s m%0d rsp", tag, i),
                  128'({m_ack[i], m_err[i], m_rty[i], m_rdat[i], m_rtgd[i]}),
                  128'({e_ack[i], e_err[i], e_rty[i],
                        (i == owner) ? {t_rdat, t_rtgd} : {(DAT_W + TGD_W){1'b0}}}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        m_cyc = '0; m_stb = '0;
        t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [N-1:0] cyc;
        logic         tack;
        int           owner;
        logic         tcyc;
        logic [N-1:0] ack;
    } vec_t;
    vec_t vecs [15];

    // Reference model state for the random phase.
    int owner_m, last_m, wd_m, c_m;
    logic stall;
    int grants [9];
    int ngr;
    logic prev_busy;
    logic [N-1:0] dropped;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            m_adr[i] = 32'h1000 * (i + 1);
            m_sel[i] = 4'hF;
            m_tgd[i] = 4'(i + 1);
        end
        m_dat[0] = 32'hA5A5A5A5;
        m_dat[1] = 32'h11111111;
        m_dat[2] = 32'h22222222;
        m_cyc = '0; m_stb = '0; m_we = '0;
        t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0;
        t_rdat = 32'hCAFE0001; t_rtgd = 4'h9;

        //               cyc    ack  owner tcyc ack
        vecs[0]  = '{3'b000, 1'b0, -1, 1'b0, 3'b000};
        vecs[1]  = '{3'b011, 1'b0, -1, 1'b0, 3'b000};
        vecs[2]  = '{3'b011, 1'b1,  0, 1'b1, 3'b001};
        vecs[3]  = '{3'b010, 1'b0,  0, 1'b0, 3'b000};
        vecs[4]  = '{3'b011, 1'b0, -1, 1'b0, 3'b000};
        vecs[5]  = '{3'b011, 1'b1,  1, 1'b1, 3'b010};
        vecs[6]  = '{3'b001, 1'b0,  1, 1'b0, 3'b000};
        vecs[7]  = '{3'b011, 1'b0, -1, 1'b0, 3'b000};
        vecs[8]  = '{3'b011, 1'b1,  0, 1'b1, 3'b001};
        vecs[9]  = '{3'b000, 1'b0,  0, 1'b0, 3'b000};
        vecs[10] = '{3'b000, 1'b0, -1, 1'b0, 3'b000};
        vecs[11] = '{3'b001, 1'b0, -1, 1'b0, 3'b000};
        vecs[12] = '{3'b001, 1'b1,  0, 1'b1, 3'b001};
        vecs[13] = '{3'b000, 1'b0,  0, 1'b0, 3'b000};
        vecs[14] = '{3'b000, 1'b0, -1, 1'b0, 3'b000};

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", -1, 1'b0, 1'b0, '0, '0, '0);
        check("reset grant", 128'(grant), 128'(0));
        reset = 1'b0;

        // Contention and single-master write, from reset
        for (int s = 0; s < 15; s++) begin
            m_cyc = vecs[s].cyc; m_stb = vecs[s].cyc; m_we = vecs[s].cyc;
            t_ack = vecs[s].tack;
            #4;
            check_outputs($sformatf("vec%0d", s), vecs[s].owner, vecs[s].tcyc, vecs[s].tcyc,
                          vecs[s].ack, '0, '0);
            tick();
        end

        // Watchdog: err on 5th unanswered strobe, then an ack exactly at the limit
        pulse_reset();
        m_cyc = 3'b001; m_stb = 3'b001;
        #4;
        check_outputs("wd idle", -1, 1'b0, 1'b0, '0, '0, '0);
        tick();
        for (int j = 1; j <= 11; j++) begin
            t_ack = (j == 10);
            #4;
            check_outputs($sformatf("wd%0d", j), 0, 1'b1, !(j == 5 || j == 10),
                          (j == 10) ? 3'b001 : 3'b000, (j == 5) ? 3'b001 : 3'b000, '0);
            tick();
        end
        t_ack = 1'b0; m_cyc = '0; m_stb = '0;
        #4;
        check_outputs("wd release", 0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        #4;
        check_outputs("wd idle2", -1, 1'b0, 1'b0, '0, '0, '0);
        tick();

        // Starvation: three masters re-requesting right after each ack
        pulse_reset();
        t_ack = 1'b1; prev_busy = 1'b0; ngr = 0; dropped = '0;
        for (int c = 0; c < 60 && ngr < 9; c++) begin
            m_cyc = ~dropped; m_stb = ~dropped;
            #4;
            if (busy && !prev_busy) begin
                grants[ngr] = int'(grant);
                ngr++;
            end
            dropped = m_ack & m_cyc;
            prev_busy = busy;
            tick();
        end
        check("starve grants", 128'(ngr), 128'(9));
        for (int k = 0; k < ngr; k++)
            check($sformatf("starve g%0d", k), 128'(grants[k]), 128'(k % 3));

        // Reset between edges during an m1 grant
        pulse_reset();
        m_cyc = 3'b010; m_stb = 3'b010; t_ack = 1'b1;
        #4;
        check_outputs("rst idle", -1, 1'b0, 1'b0, '0, '0, '0);
        tick();
        #4;
        check_outputs("rst m1", 1, 1'b1, 1'b1, 3'b010, '0, '0);
        #1;
        reset = 1'b1;
        #1;
        check_outputs("rst async", -1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        reset = 1'b0;
        m_cyc = 3'b011; m_stb = 3'b011;
        tick();
        #4;
        check_outputs("rst after", 0, 1'b1, 1'b1, 3'b001, '0, '0);
        tick();

        // Randomized traffic against the reference model
        pulse_reset();
        owner_m = -1; last_m = N - 1; wd_m = 0; stall = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic resp, gstb, limit, fire;
            logic [N-1:0] ea, ee, er;
            if ($urandom_range(19) == 0) stall = ~stall;
            for (int i = 0; i < N; i++) begin
                if (m_cyc[i]) m_cyc[i] = ($urandom_range(9) != 0);
                else          m_cyc[i] = ($urandom_range(2) == 0);
                m_stb[i] = m_cyc[i] & (stall | ($urandom_range(3) != 0));
                m_we[i]  = 1'($urandom);
                m_adr[i] = $urandom;
                m_dat[i] = $urandom;
                m_sel[i] = 4'($urandom);
                m_tgd[i] = 4'($urandom);
            end
            c_m = stall ? 15 : $urandom_range(15);
            t_ack = (c_m < 6); t_err = (c_m == 6); t_rty = (c_m == 7);
            t_rdat = $urandom; t_rtgd = 4'($urandom);
            #4;
            resp  = t_ack | t_err | t_rty;
            gstb  = (owner_m >= 0) && m_stb[owner_m];
            limit = gstb && (wd_m == TO);
            fire  = limit && !resp;
            ea = '0; ee = '0; er = '0;
            if (owner_m >= 0) begin
                ea[owner_m] = t_ack;
                ee[owner_m] = t_err | fire;
                er[owner_m] = t_rty;
            end
            check_outputs($sformatf("rnd%0d", cyc), owner_m,
                          (owner_m >= 0) && m_cyc[owner_m], gstb && !limit, ea, ee, er);
            if (owner_m < 0) begin
                for (int k = 1; k <= N; k++) begin
                    c_m = (last_m + k) % N;
                    if (owner_m < 0 && m_cyc[c_m]) owner_m = c_m;
                end
                wd_m = 0;
            end else if (!m_cyc[owner_m]) begin
                last_m = owner_m; owner_m = -1; wd_m = 0;
            end else if (resp || !gstb || limit) begin
                wd_m = 0;
            end else begin
                wd_m++;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
